// File: rtl/smp_mem_arbiter.sv
// Round-robin arbiter for the shared SMP data memory with snoop, cache-to-cache transfer and dirty writeback.
// Optional event counters (stat_gnt0/stat_gnt1/stat_c2c) are built when SMP_ARB_STATS_EN is defined.
module smp_mem_arbiter #(
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 32,
    parameter int SNOOP_TO = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_rd,
    input  logic [1:0]             req_wr,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             gnt,
    output logic [1:0]             rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_shared,
    output logic [1:0]             snoop_valid,
    output logic [ADDR_W-1:0]      snoop_addr,
    output logic                   snoop_inv,
    input  logic [1:0]             snoop_ack,
    input  logic [1:0]             snoop_hit,
    input  logic [1:0]             snoop_dirty,
    input  logic [1:0][DATA_W-1:0] snoop_data,
    output logic                   mem_rden,
    output logic                   mem_wren,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_valid
`ifdef SMP_ARB_STATS_EN
    ,
    output logic [15:0]            stat_gnt0,
    output logic [15:0]            stat_gnt1,
    output logic [15:0]            stat_c2c
`endif
);

    localparam int CNT_W = $clog2(SNOOP_TO + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(SNOOP_TO - 1);

    typedef enum logic [2:0] {IDLE, SNOOP, MEM_RD, MEM_WR, WB, RESP} state_t;

    state_t              state_q, state_d;
    logic                id_q, id_d;
    logic                op_q, op_d;
    logic                rr_q, rr_d;
    logic                shared_q, shared_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_shared_q, rsp_shared_d;
    logic [1:0]          active;
    logic [1:0]          gnt_c;
    logic                sel;
    logic                oth;

    assign active = req_rd | req_wr;
    assign sel    = (active == 2'b11) ? rr_q : active[1];
    assign oth    = ~id_q;

    // A held request must not see a grant while reset is asserted.
    assign gnt        = gnt_c & {2{reset}};
    assign rsp_data   = rsp_data_q;
    assign rsp_shared = rsp_shared_q;

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        op_d         = op_q;
        rr_d         = rr_q;
        shared_d     = shared_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sdata_d      = sdata_q;
        rsp_data_d   = rsp_data_q;
        rsp_shared_d = rsp_shared_q;
        gnt_c        = '0;
        rsp_valid    = '0;
        snoop_valid  = '0;
        snoop_addr   = '0;
        snoop_inv    = 1'b0;
        mem_rden     = 1'b0;
        mem_wren     = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state_q)
            IDLE: begin
                if (|active) begin
                    gnt_c[sel] = 1'b1;
                    id_d       = sel;
                    op_d       = req_wr[sel];
                    addr_d     = req_addr[sel];
                    wdata_d    = req_wdata[sel];
                    cnt_d      = '0;
                    state_d    = SNOOP;
                end
            end
            SNOOP: begin
                snoop_valid[oth] = 1'b1;
                snoop_addr       = addr_q;
                snoop_inv        = op_q;
                if (snoop_ack[oth]) begin
                    if (op_q) begin
                        shared_d = snoop_hit[oth];
                        state_d  = MEM_WR;
                    end else if (snoop_hit[oth] && snoop_dirty[oth]) begin
                        sdata_d  = snoop_data[oth];
                        shared_d = 1'b1;
                        state_d  = WB;
                    end else begin
                        shared_d = snoop_hit[oth];
                        state_d  = MEM_RD;
                    end
                end else if (cnt_q == TO_LAST) begin
                    // Silent peer: proceed as a snoop miss.
                    shared_d = 1'b0;
                    state_d  = op_q ? MEM_WR : MEM_RD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEM_RD: begin
                mem_rden = 1'b1;
                mem_addr = addr_q;
                if (mem_valid) begin
                    sdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            MEM_WR: begin
                mem_wren  = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_valid) begin
                    sdata_d = wdata_q;
                    state_d = RESP;
                end
            end
            WB: begin
                mem_wren  = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = sdata_q;
                if (mem_valid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[id_q] = 1'b1;
                rr_d            = ~id_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Response payload is loaded on RESP entry and holds until the next one.
        if (state_d == RESP && state_q != RESP) begin
            rsp_data_d   = sdata_d;
            rsp_shared_d = shared_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            id_q         <= 1'b0;
            op_q         <= 1'b0;
            rr_q         <= 1'b0;
            shared_q     <= 1'b0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_shared_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            op_q         <= op_d;
            rr_q         <= rr_d;
            shared_q     <= shared_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_shared_q <= rsp_shared_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        sdata_q <= sdata_d;
    end

`ifdef SMP_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_gnt0 <= '0;
            stat_gnt1 <= '0;
            stat_c2c  <= '0;
        end else begin
            if (gnt[0]) stat_gnt0 <= sat_inc(stat_gnt0);
            if (gnt[1]) stat_gnt1 <= sat_inc(stat_gnt1);
            if (state_d == WB && state_q != WB) stat_c2c <= sat_inc(stat_c2c);
        end
    end
`endif

endmodule

// File: tb/tb_smp_mem_arbiter.sv
// Directed bench for smp_mem_arbiter: read miss, round-robin, write invalidate, dirty c2c, snoop timeout, reset mid-access.
module tb_smp_mem_arbiter;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [1:0]             req_rd, req_wr;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             gnt, rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic                   rsp_shared;
    logic [1:0]             snoop_valid;
    logic [ADDR_W-1:0]      snoop_addr;
    logic                   snoop_inv;
    logic [1:0]             snoop_ack, snoop_hit, snoop_dirty;
    logic [1:0][DATA_W-1:0] snoop_data;
    logic                   mem_rden, mem_wren;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata, mem_rdata;
    logic                   mem_valid;
`ifdef SMP_ARB_STATS_EN
    logic [15:0]            stat_gnt0, stat_gnt1, stat_c2c;
`endif

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    smp_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SNOOP_TO(15)) dut (
        .clk(clk), .reset(reset),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_shared(rsp_shared),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_inv(snoop_inv),
        .snoop_ack(snoop_ack), .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
        .snoop_data(snoop_data),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
`ifdef SMP_ARB_STATS_EN
        , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_c2c(stat_c2c)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b0; req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        snoop_ack = '0; snoop_hit = '0; snoop_dirty = '0; snoop_data = '0;
        mem_rdata = '0; mem_valid = 1'b0;
        cyc(); cyc();
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_data", 64'(rsp_data), 64'h0);
        chk("rst_rsp_shared", 64'(rsp_shared), 64'h0);
        chk("rst_snoop_valid", 64'(snoop_valid), 64'h0);
        chk("rst_mem_strobes", 64'({mem_rden, mem_wren}), 64'h0);
        reset = 1'b1;
        cyc();

        // Core0 read miss, minimum latency
        req_rd = 2'b01; req_addr[0] = 2'd2; snoop_ack = 2'b10;
        settle(); chk("t1_gnt", 64'(gnt), 64'h1);
        cyc(); req_rd = '0; mem_valid = 1'b1; mem_rdata = 32'hA5A5_0001;
        settle();
        chk("t1_snoop_valid", 64'(snoop_valid), 64'h2);
        chk("t1_snoop_addr", 64'(snoop_addr), 64'h2);
        chk("t1_snoop_inv", 64'(snoop_inv), 64'h0);
        chk("t1_rsp_early", 64'(rsp_valid), 64'h0);
        cyc(); snoop_ack = '0;
        settle();
        chk("t1_mem_rden", 64'(mem_rden), 64'h1);
        chk("t1_mem_addr", 64'(mem_addr), 64'h2);
        cyc(); mem_valid = 1'b0;
        settle();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_data", 64'(rsp_data), 64'hA5A5_0001);
        chk("t1_rsp_shared", 64'(rsp_shared), 64'h0);
        cyc();
        chk("t1_rsp_pulse", 64'(rsp_valid), 64'h0);
        chk("t1_rsp_hold", 64'(rsp_data), 64'hA5A5_0001);

        // Round-robin after a fresh reset
        reset = 1'b0; settle(); cyc(); reset = 1'b1;
        req_rd = 2'b11; req_addr[0] = 2'd0; req_addr[1] = 2'd1;
        snoop_ack = 2'b11; mem_valid = 1'b1; mem_rdata = 32'h11;
        settle(); chk("rr_gnt_first", 64'(gnt), 64'h1);
        cyc(); req_rd = 2'b10;
        cyc(); cyc();
        chk("rr_rsp0", 64'(rsp_valid), 64'h1);
        chk("rr_no_gnt_in_resp", 64'(gnt), 64'h0);
        cyc();
        chk("rr_gnt_second", 64'(gnt), 64'h2);
        cyc(); req_rd = '0;
        cyc(); cyc();
        chk("rr_rsp1", 64'(rsp_valid), 64'h2);
        cyc(); req_rd = 2'b11;
        settle(); chk("rr_gnt_back0", 64'(gnt), 64'h1);
        cyc(); req_rd = '0;
        cyc(); cyc(); cyc();

        // Core1 write (rd+wr both set) invalidates core0
        req_rd = 2'b10; req_wr = 2'b10; req_addr[1] = 2'd1; req_wdata[1] = 32'hDEAD_BEEF;
        snoop_ack = 2'b01; snoop_hit = 2'b01;
        settle(); chk("wr_gnt", 64'(gnt), 64'h2);
        cyc(); req_rd = '0; req_wr = '0;
        settle();
        chk("wr_snoop_valid", 64'(snoop_valid), 64'h1);
        chk("wr_snoop_inv", 64'(snoop_inv), 64'h1);
        chk("wr_snoop_addr", 64'(snoop_addr), 64'h1);
        cyc();
        chk("wr_mem_strobes", 64'({mem_rden, mem_wren}), 64'h1);
        chk("wr_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        chk("wr_mem_addr", 64'(mem_addr), 64'h1);
        cyc();
        chk("wr_rsp_valid", 64'(rsp_valid), 64'h2);
        cyc();

        // Core0 read, core1 holds the line dirty
        req_rd = 2'b01; req_addr[0] = 2'd3; snoop_ack = 2'b10; snoop_hit = 2'b10;
        snoop_dirty = 2'b10; snoop_data[1] = 32'h1234_5678; mem_rdata = 32'hFFFF_FFFF;
        mem_valid = 1'b0;
        settle(); chk("c2c_gnt", 64'(gnt), 64'h1);
        cyc(); req_rd = '0;
        cyc();
        chk("c2c_mem_strobes", 64'({mem_rden, mem_wren}), 64'h1);
        chk("c2c_mem_wdata", 64'(mem_wdata), 64'h1234_5678);
        chk("c2c_mem_addr", 64'(mem_addr), 64'h3);
        cyc(); mem_valid = 1'b1;
        settle();
        chk("c2c_wren_held", 64'({mem_rden, mem_wren}), 64'h1);
        cyc();
        chk("c2c_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("c2c_rsp_data", 64'(rsp_data), 64'h1234_5678);
        chk("c2c_rsp_shared", 64'(rsp_shared), 64'h1);
        cyc();

        // Snoop timeout; own-core ack and stale hit must be ignored
        req_rd = 2'b01; req_addr[0] = 2'd0; snoop_ack = 2'b01; snoop_hit = 2'b10;
        snoop_dirty = '0; mem_rdata = 32'hCAFE_0005;
        settle(); chk("to_gnt", 64'(gnt), 64'h1);
        cyc(); req_rd = '0;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("to_snoop_valid_%0d", i), 64'(snoop_valid), 64'h2);
            cyc();
        end
        chk("to_snoop_drop", 64'(snoop_valid), 64'h0);
        chk("to_mem_rden", 64'(mem_rden), 64'h1);
        cyc();
        chk("to_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("to_rsp_shared", 64'(rsp_shared), 64'h0);
        chk("to_rsp_data", 64'(rsp_data), 64'hCAFE_0005);
        cyc();

        // Reset asserted during MEM_RD
        req_rd = 2'b01; req_addr[0] = 2'd2; snoop_ack = 2'b10; snoop_hit = '0; mem_valid = 1'b0;
        settle(); chk("mr_gnt", 64'(gnt), 64'h1);
        cyc(); req_rd = 2'b11;
        cyc();
        chk("mr_mem_rden", 64'(mem_rden), 64'h1);
        reset = 1'b0;
        settle();
        chk("mr_rst_gnt", 64'(gnt), 64'h0);
        chk("mr_rst_mem_rden", 64'(mem_rden), 64'h0);
        chk("mr_rst_mem_addr", 64'(mem_addr), 64'h0);
        chk("mr_rst_rsp_data", 64'(rsp_data), 64'h0);
        chk("mr_rst_snoop_valid", 64'(snoop_valid), 64'h0);
        mem_valid = 1'b1;
        cyc();
        chk("mr_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        cyc(); reset = 1'b1;
        settle();
        chk("mr_regrant_rr0", 64'(gnt), 64'h1);
        chk("mr_no_rsp", 64'(rsp_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
